// File: rtl/median_wake_detector_if.sv
// Bus bundle for median_wake_detector: control/threshold in, pixel
// address/data, window results, frame status and wake flag.
interface median_wake_detector_if #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int WIN   = 2
);
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int NWX = IMG_W / WIN;
    localparam int NWY = IMG_H / WIN;
    localparam int CW  = $clog2(NWX * NWY + 1);
    // Window-coordinate widths kept at least 1 bit for single-window dims.
    localparam int MXW = (NWX > 1) ? $clog2(NWX) : 1;
    localparam int MYW = (NWY > 1) ? $clog2(NWY) : 1;

    logic           start;
    logic           wake_clear;
    logic [CW-1:0]  threshold;
    logic           data_in;
    logic [XW-1:0]  x_addr;
    logic [YW-1:0]  y_addr;
    logic           rd_en;
    logic           busy;
    logic           median_valid;
    logic           median_bit;
    logic [MXW-1:0] med_x;
    logic [MYW-1:0] med_y;
    logic           frame_done;
    logic [CW-1:0]  active_count;
    logic           wake;

    modport slave (
        input  start, wake_clear, threshold, data_in,
        output x_addr, y_addr, rd_en, busy, median_valid, median_bit,
               med_x, med_y, frame_done, active_count, wake
    );

    modport master (
        output start, wake_clear, threshold, data_in,
        input  x_addr, y_addr, rd_en, busy, median_valid, median_bit,
               med_x, med_y, frame_done, active_count, wake
    );
endinterface

// File: rtl/median_wake_detector.sv
// Binary median over non-overlapping WIN x WIN windows of a frame read
// one pixel per cycle, with per-frame active-window count and a sticky
// wake flag gated on CONSEC consecutive over-threshold frames.
module median_wake_detector #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int WIN     = 2,
    parameter int MED_MIN = (WIN * WIN) / 2 + 1,
    parameter int CONSEC  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    median_wake_detector_if.slave  bus
);
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int NWX = IMG_W / WIN;
    localparam int NWY = IMG_H / WIN;
    localparam int CW  = $clog2(NWX * NWY + 1);
    localparam int MXW = (NWX > 1) ? $clog2(NWX) : 1;
    localparam int MYW = (NWY > 1) ? $clog2(NWY) : 1;
    localparam int PW  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int OW  = $clog2(WIN * WIN + 1);
    localparam int SW  = 4;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t         r_state;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [PW-1:0]  r_px, r_py;
    logic [MXW-1:0] r_wx;
    logic [MYW-1:0] r_wy;
    logic           r_rd_en, r_busy, r_frame_done, r_wake;
    logic [CW-1:0]  r_thr, r_active;
    logic [SW-1:0]  r_streak;

    // Sample-stage tags travel one cycle behind the address they belong to.
    logic           r_pvld, r_plast;
    logic [MXW-1:0] r_pwx, r_mx;
    logic [MYW-1:0] r_pwy, r_my;
    logic [OW-1:0]  r_ones;
    logic           r_mvld, r_mbit;
    logic [CW-1:0]  r_count;

    logic           w_win_last, w_frame_last, w_accept, w_hit, w_bit;
    logic [SW-1:0]  w_streak_n;
    logic [OW-1:0]  w_ones_n;

    assign w_win_last   = (r_px == PW'(WIN - 1)) && (r_py == PW'(WIN - 1));
    assign w_frame_last = w_win_last && (r_wx == MXW'(NWX - 1)) && (r_wy == MYW'(NWY - 1));
    assign w_accept     = (r_state == S_IDLE) && bus.start;
    assign w_hit        = r_count > r_thr;
    assign w_streak_n   = !w_hit ? '0 :
                          (r_streak == SW'(CONSEC)) ? r_streak : r_streak + 1'b1;
    assign w_ones_n     = r_ones + OW'(bus.data_in);
    assign w_bit        = w_ones_n >= OW'(MED_MIN);

    // Scan FSM: address generation, frame completion and wake/streak tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x <= '0; r_y <= '0; r_px <= '0; r_py <= '0; r_wx <= '0; r_wy <= '0;
            r_rd_en <= 1'b0; r_busy <= 1'b0; r_frame_done <= 1'b0; r_wake <= 1'b0;
            r_thr <= '0; r_active <= '0; r_streak <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_thr   <= bus.threshold;
                    r_x <= '0; r_y <= '0; r_px <= '0; r_py <= '0; r_wx <= '0; r_wy <= '0;
                    r_rd_en <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (w_frame_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (r_px != PW'(WIN - 1)) begin
                        r_px <= r_px + 1'b1;
                        r_x  <= r_x + 1'b1;
                    end else if (r_py != PW'(WIN - 1)) begin
                        // next row inside the same window
                        r_px <= '0;
                        r_py <= r_py + 1'b1;
                        r_x  <= r_x - XW'(WIN - 1);
                        r_y  <= r_y + 1'b1;
                    end else if (r_wx != MXW'(NWX - 1)) begin
                        // next window to the right, back to its top row
                        r_px <= '0; r_py <= '0;
                        r_wx <= r_wx + 1'b1;
                        r_x  <= r_x + 1'b1;
                        r_y  <= r_y - YW'(WIN - 1);
                    end else begin
                        // first window of the next window row
                        r_px <= '0; r_py <= '0; r_wx <= '0;
                        r_wy <= r_wy + 1'b1;
                        r_x  <= '0;
                        r_y  <= r_y + 1'b1;
                    end
                end
                S_DRAIN: if (!r_pvld) begin
                    // last sample consumed, so r_count is final
                    r_frame_done <= 1'b1;
                    r_active     <= r_count;
                    r_streak     <= w_streak_n;
                    if (w_streak_n == SW'(CONSEC)) r_wake <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // Clear overrides any streak/wake update, including this frame's hit.
            if (bus.wake_clear) begin
                r_wake   <= 1'b0;
                r_streak <= '0;
            end
        end
    end

    // Data path: accumulate ones per window, emit result, count active windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pvld <= 1'b0; r_plast <= 1'b0; r_pwx <= '0; r_pwy <= '0;
            r_ones <= '0; r_mvld <= 1'b0; r_mbit <= 1'b0; r_mx <= '0; r_my <= '0;
            r_count <= '0;
        end else begin
            r_pvld  <= r_rd_en;
            r_plast <= w_win_last;
            r_pwx   <= r_wx;
            r_pwy   <= r_wy;
            r_mvld  <= 1'b0;
            if (w_accept) begin
                r_ones  <= '0;
                r_count <= '0;
            end else if (r_pvld) begin
                if (r_plast) begin
                    r_ones <= '0;
                    r_mvld <= 1'b1;
                    r_mbit <= w_bit;
                    r_mx   <= r_pwx;
                    r_my   <= r_pwy;
                    if (w_bit) r_count <= r_count + 1'b1;
                end else begin
                    r_ones <= w_ones_n;
                end
            end
        end
    end

    assign bus.x_addr       = r_x;
    assign bus.y_addr       = r_y;
    assign bus.rd_en        = r_rd_en;
    assign bus.busy         = r_busy;
    assign bus.median_valid = r_mvld;
    assign bus.median_bit   = r_mbit;
    assign bus.med_x        = r_mx;
    assign bus.med_y        = r_my;
    assign bus.frame_done   = r_frame_done;
    assign bus.active_count = r_active;
    assign bus.wake         = r_wake;
endmodule

// File: doc/median_wake_detector.md
Name: median_wake_detector

Overview:
- Parametrised successor to the fixed 160x120 binary median/wake top. It owns its own scan FSM.
- Reads a binary frame from external pixel memory one pixel per cycle and computes a per-window majority (binary median) over non-overlapping WIN x WIN windows.
- Writes each window result out and counts active windows per frame.
- Raises a sticky wake flag only after CONSEC consecutive frames exceed a programmable threshold.

Parameters:
- IMG_W, 160, frame width in pixels; must be a multiple of WIN.
- IMG_H, 120, frame height in pixels; must be a multiple of WIN.
- WIN, 2, window edge in pixels.
- MED_MIN, (WIN*WIN)/2+1, number of ones at or above which a window is active.
- CONSEC, 2, consecutive over-threshold frames required to assert wake; range 1..15.
- Derived (localparam, not overridable): XW=$clog2(IMG_W), YW=$clog2(IMG_H), NWX=IMG_W/WIN, NWY=IMG_H/WIN, CW=$clog2(NWX*NWY+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a frame scan when idle.
- wake_clear  in  1  single-cycle pulse; clears wake and streak.
- threshold  in  CW  active-window threshold; sampled on accepted start.
- data_in  in  1  pixel from memory; valid one cycle after its address.
- x_addr  out  XW  pixel column address.
- y_addr  out  YW  pixel row address.
- rd_en  out  1  address valid this cycle.
- busy  out  1  high from accepted start through frame_done.
- median_valid  out  1  one-cycle pulse per window result.
- median_bit  out  1  window result (1 = active).
- med_x  out  $clog2(NWX)  window column of current result.
- med_y  out  $clog2(NWY)  window row of current result.
- frame_done  out  1  one-cycle pulse at end of frame.
- active_count  out  CW  active windows of the last completed frame; held until the next frame_done.
- wake  out  1  sticky wake flag.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, streak 0, internal counters 0.
- FSM states: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 latches threshold, clears the running count and window accumulator, moves to SCAN, and sets busy=1 the next cycle. start is ignored in every other state.
- SCAN: rd_en=1 and one address per cycle.
  - Order: windows raster (left-right, then top-bottom); pixels inside a window row-major.
  - Pixel address = (wx*WIN+px, wy*WIN+py).
  - After the last pixel of the last window (x=IMG_W-1, y=IMG_H-1), go to DRAIN; rd_en=0 from then on.
- Data path: data_in is sampled the cycle after its address and accumulated into a ones counter of $clog2(WIN*WIN+1) bits.
  - On the cycle the last pixel of a window is sampled, the registered result updates on the next edge: median_valid=1, median_bit=(ones>=MED_MIN), med_x/med_y = that window's coordinates.
  - The accumulator restarts for the next window with no bubble.
  - The running count increments when median_bit=1.
- DRAIN: waits until the final window result is registered, then moves to DONE.
- DONE (one cycle): frame_done=1, active_count=final count, busy drops to 0 on the next cycle.
  - hit = (count > latched threshold), a strict compare; equal is not a hit.
  - hit: streak increments, saturating at CONSEC. Otherwise streak is cleared to 0.
  - When streak reaches CONSEC, wake is set in the same edge as frame_done.
- Latency, with start accepted at cycle 0 and P=IMG_W*IMG_H:
  - First address at cycle 1, last address at cycle P.
  - Last median_valid at cycle P+2.
  - frame_done at cycle P+3.
  - Next start accepted at P+4 at the earliest.
- wake: once set, it stays 1 across later frames regardless of hits until wake_clear or reset.
  - wake_clear clears wake and streak.
  - wake_clear coinciding with the DONE cycle: clear wins. wake=0, streak=0, and that frame's hit is discarded.
- Reset mid-frame: the scan aborts immediately and everything returns to reset values; the partial frame produces no frame_done.
- Counts: active_count never wraps; max NWX*NWY fits in CW bits.

Test Plan:
- All-zero frame, default counting (IMG_W=4, IMG_H=4, WIN=2, MED_MIN=3, CONSEC=2, threshold=1), start at cycle 0:
  - Address sequence is (0,0),(1,0),(0,1),(1,1),(2,0)...
  - Four median_valid pulses, all with median_bit=0.
  - frame_done at cycle 19, active_count=0, wake=0.
- Majority/tie (same config): windows loaded with 4, 3, 2 and 1 ones.
  - median_bit sequence is 1,1,0,0; active_count=2.
  - Since 2>1 this is a hit, streak=1, wake stays 0.
- Consecutive gating (same config): three all-ones frames.
  - Each frame gives active_count=4.
  - wake rises at the second frame_done and stays 1 after the third.
- Strict compare and streak reset (threshold=4):
  - An all-ones frame gives count=4, not a hit, streak 0.
  - With threshold=3: hit, then a zero frame (streak cleared), then a hit frame. wake stays 0.
- wake_clear collision: wake already 1, wake_clear pulsed in the frame_done cycle of a hit frame.
  - wake=0 and streak=0; the next hit frame alone does not set wake.
- Robustness: reset asserted at cycle 7 mid-scan, and start pulsed during SCAN.
  - After reset: all outputs 0, no frame_done, and a new start behaves as a fresh frame.
  - The start pulsed during SCAN is ignored; the address sequence is unchanged.
